// File: rtl/ann_pkg.sv
// Shared types and arithmetic helpers for the neuron MAC datapath.
package ann_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            sat = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            sat = SAT_MIN[DATA_W-1:0];
        end else begin
            sat = v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/mac_sat_unit.sv
// Signed multiply-accumulate with deferred scaling, bias add and saturation.
module mac_sat_unit
    import ann_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc_en,
    input  logic              fin,
    input  logic [DATA_W-1:0] bias,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] result
);

    logic signed [ACC_W-1:0]    acc;
    logic        [DATA_W-1:0]   bias_r;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    sum;

    assign prod     = $signed(w) * $signed(x);
    assign prod_ext = {{(ACC_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W - DATA_W){bias_r[DATA_W-1]}}, bias_r};
    // Scale once after accumulation so the floor is taken on the full sum.
    assign sum      = (acc >>> FRAC_BITS) + bias_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            bias_r <= '0;
            result <= '0;
        end else begin
            if (clr) begin
                acc    <= '0;
                bias_r <= bias;
            end else if (acc_en) begin
                acc <= acc + prod_ext;
            end
            if (fin) begin
                result <= sat(sum);
            end
        end
    end

endmodule

// File: rtl/weight_row_mac_ctrl.sv
// Dot-product sequencer for one neuron; owns the weight BRAM write port while idle.
module weight_row_mac_ctrl
    import ann_pkg::*;
#(
    parameter int NUM_W  = 28,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] BIAS,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RESULT,
    input  logic              LOAD_WE,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [DATA_W-1:0] LOAD_DATA,
    output logic              LOAD_BUSY,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [DATA_W-1:0] W_DI,
    output logic              W_EN,
    output logic              W_WE,
    input  logic [DATA_W-1:0] W_DO,
    output logic [ADDR_W-1:0] X_ADDR,
    output logic              X_EN,
    input  logic [DATA_W-1:0] X_DO
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_W - 1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_n;
    logic              en_r;
    logic              en_n;
    logic              done_r;
    logic              clr;
    logic              acc_en;
    logic              fin;
    logic              idle;
    logic              load_ok;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr_r;
        en_n    = en_r;
        clr     = 1'b0;
        acc_en  = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_n = READ;
                    addr_n  = '0;
                    en_n    = 1'b1;
                    clr     = 1'b1;
                end
            end
            READ: begin
                acc_en = 1'b1;
                addr_n = addr_r + 1'b1;
                if (addr_n == LAST) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                // Enable held through the last issue cycle so address NUM_W-1 is read.
                acc_en  = 1'b1;
                en_n    = 1'b0;
                addr_n  = '0;
                state_n = FINISH;
            end
            FINISH: begin
                fin     = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_r <= '0;
            en_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            addr_r <= addr_n;
            en_r   <= en_n;
            done_r <= fin;
        end
    end

    mac_sat_unit u_mac (
        .clk    (CLK),
        .rst    (RST),
        .clr    (clr),
        .acc_en (acc_en),
        .fin    (fin),
        .bias   (BIAS),
        .w      (W_DO),
        .x      (X_DO),
        .result (RESULT)
    );

    assign idle      = (state == IDLE);
    assign load_ok   = idle & LOAD_WE & ~START;
    assign BUSY      = ~idle;
    assign DONE      = done_r;
    assign LOAD_BUSY = ~idle | START;

    assign W_ADDR = idle ? LOAD_ADDR : addr_r;
    assign W_DI   = idle ? LOAD_DATA : '0;
    assign W_EN   = idle ? load_ok : en_r;
    assign W_WE   = load_ok;
    assign X_ADDR = addr_r;
    assign X_EN   = en_r;

endmodule

// File: tb/tb_weight_row_mac_ctrl.sv
// Directed bench for weight_row_mac_ctrl with falling-edge BRAM models.
module tb_weight_row_mac_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] BIAS = '0;
    logic        BUSY;
    logic        DONE;
    logic [15:0] RESULT;
    logic        LOAD_WE = 1'b0;
    logic [4:0]  LOAD_ADDR = '0;
    logic [15:0] LOAD_DATA = '0;
    logic        LOAD_BUSY;
    logic [4:0]  W_ADDR;
    logic [15:0] W_DI;
    logic        W_EN;
    logic        W_WE;
    logic [15:0] W_DO = '0;
    logic [4:0]  X_ADDR;
    logic        X_EN;
    logic [15:0] X_DO = '0;

    logic [15:0] wmem [0:27];
    logic [15:0] xmem [0:27];

    int tests = 0;
    int fails = 0;
    int lat;
    int nd;
    logic [15:0] res;

    always #5 CLK = ~CLK;

    weight_row_mac_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .BIAS      (BIAS),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .LOAD_WE   (LOAD_WE),
        .LOAD_ADDR (LOAD_ADDR),
        .LOAD_DATA (LOAD_DATA),
        .LOAD_BUSY (LOAD_BUSY),
        .W_ADDR    (W_ADDR),
        .W_DI      (W_DI),
        .W_EN      (W_EN),
        .W_WE      (W_WE),
        .W_DO      (W_DO),
        .X_ADDR    (X_ADDR),
        .X_EN      (X_EN),
        .X_DO      (X_DO)
    );

    always @(negedge CLK) begin
        if (W_EN && W_ADDR < 5'd28) begin
            if (W_WE) wmem[W_ADDR] <= W_DI;
            W_DO <= wmem[W_ADDR];
        end
        if (X_EN && X_ADDR < 5'd28) begin
            X_DO <= xmem[X_ADDR];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < 28; i++) begin
            wmem[i] = w;
            xmem[i] = x;
        end
    endtask

    task automatic run(input logic [15:0] bias, input bit ld0, input int ld_at,
                       input int st_at, input int rst_at,
                       output int lt, output int ndone, output logic [15:0] r);
        BIAS  = bias;
        START = 1'b1;
        if (ld0) begin
            LOAD_WE   = 1'b1;
            LOAD_ADDR = 5'd7;
            LOAD_DATA = 16'hBEEF;
            #1;
            chk("st_ld_we", W_WE, 0);
            chk("st_ld_busy", LOAD_BUSY, 1);
        end
        @(posedge CLK);
        #1;
        START   = 1'b0;
        LOAD_WE = 1'b0;
        lt      = -1;
        ndone   = 0;
        r       = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            LOAD_WE = 1'b0;
            START   = 1'b0;
            if (RST) begin
                RST = 1'b0;
                chk("rst_busy", BUSY, 0);
                chk("rst_done", DONE, 0);
                chk("rst_result", RESULT, 0);
                chk("rst_w_en", W_EN, 0);
                chk("rst_x_en", X_EN, 0);
            end
            if (DONE) begin
                ndone++;
                if (lt < 0) begin
                    lt = k;
                    r  = RESULT;
                end
            end
            if (k == ld_at) begin
                LOAD_WE   = 1'b1;
                LOAD_ADDR = 5'd3;
                LOAD_DATA = 16'hDEAD;
                #1;
                chk("busy_ld_we", W_WE, 0);
                chk("busy_ld_busy", LOAD_BUSY, 1);
            end
            if (k == st_at) START = 1'b1;
            if (k == rst_at) RST = 1'b1;
        end
    endtask

    initial begin
        fill(16'h0000, 16'h0000);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("reset_busy", BUSY, 0);
        chk("reset_done", DONE, 0);
        chk("reset_result", RESULT, 0);
        chk("reset_w_en", W_EN, 0);
        chk("reset_x_en", X_EN, 0);
        chk("reset_w_we", W_WE, 0);
        chk("reset_w_addr", W_ADDR, 0);
        chk("reset_x_addr", X_ADDR, 0);
        chk("reset_w_di", W_DI, 0);
        chk("reset_load_busy", LOAD_BUSY, 0);

        fill(16'h0100, 16'h0100);
        run(16'h0000, 0, -1, -1, -1, lat, nd, res);
        chk("ones_latency", lat, 29);
        chk("ones_result", res, 16'h1C00);
        chk("ones_ndone", nd, 1);
        chk("held_result", RESULT, 16'h1C00);
        chk("idle_busy", BUSY, 0);

        fill(16'hFF00, 16'h0200);
        run(16'h0100, 0, -1, -1, -1, lat, nd, res);
        chk("neg_result", res, 16'hC900);

        fill(16'h7FFF, 16'h7FFF);
        run(16'h0000, 0, -1, -1, -1, lat, nd, res);
        chk("sat_pos", res, 16'h7FFF);

        fill(16'h8000, 16'h7FFF);
        run(16'h0000, 0, -1, -1, -1, lat, nd, res);
        chk("sat_neg", res, 16'h8000);

        fill(16'h0100, 16'h0100);
        run(16'h0000, 0, 5, -1, -1, lat, nd, res);
        chk("busy_ld_result", res, 16'h1C00);
        chk("busy_ld_mem", wmem[3], 16'h0100);

        LOAD_WE   = 1'b1;
        LOAD_ADDR = 5'd5;
        LOAD_DATA = 16'h0000;
        #1;
        chk("idle_ld_we", W_WE, 1);
        chk("idle_ld_addr", W_ADDR, 5);
        chk("idle_ld_busy", LOAD_BUSY, 0);
        @(posedge CLK);
        #1;
        LOAD_WE = 1'b0;
        chk("idle_ld_mem", wmem[5], 16'h0000);
        run(16'h0000, 0, -1, -1, -1, lat, nd, res);
        chk("rewrite_result", res, 16'h1B00);

        run(16'h0000, 1, -1, -1, -1, lat, nd, res);
        chk("st_ld_mem", wmem[7], 16'h0100);
        chk("st_ld_result", res, 16'h1B00);

        run(16'h0000, 0, -1, 10, -1, lat, nd, res);
        chk("restart_ndone", nd, 1);
        chk("restart_latency", lat, 29);
        chk("restart_result", res, 16'h1B00);

        run(16'h0000, 0, -1, -1, 9, lat, nd, res);
        chk("abort_ndone", nd, 0);
        chk("abort_result", RESULT, 0);

        run(16'h0000, 0, -1, -1, -1, lat, nd, res);
        chk("after_abort_latency", lat, 29);
        chk("after_abort_result", res, 16'h1B00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/weight_row_mac_ctrl.md
Name: weight_row_mac_ctrl

Overview:
Sequencer and access arbiter for one neuron's weight BRAM (NUM_W words × 16 bit, read and written on the falling clock edge) and its paired input-activation BRAM.
- On START: streams addresses 0..NUM_W-1 to both memories, multiplies the fixed-point pairs, accumulates, adds bias, and returns one saturated 16-bit neuron pre-activation.
- While idle: owns the weight BRAM's write path, so the host-side loader can rewrite weights without contending with compute.

Parameters:
NUM_W, 28, number of weight/input pairs per neuron (depth of the weight BRAM)
ADDR_W, 5, address width, ≥ clog2(NUM_W)
DATA_W, 16, weight/activation/bias/result width, signed two's complement
FRAC_BITS, 8, fractional bits of the Q(DATA_W-FRAC_BITS).FRAC_BITS format
ACC_W, 40, accumulator width (no overflow for NUM_W products)

Ports:
CLK  in  1  clock; all controller state changes on the rising edge
RST  in  1  synchronous, active-high reset
START  in  1  begin one dot product; sampled only in IDLE
BIAS  in  DATA_W  signed bias, sampled with START
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse, RESULT valid
RESULT  out  DATA_W  saturated sum; held until the next START is accepted
LOAD_WE  in  1  loader write request
LOAD_ADDR  in  ADDR_W  loader write address
LOAD_DATA  in  DATA_W  loader write data
LOAD_BUSY  out  1  loader write will be dropped this cycle
W_ADDR  out  ADDR_W  weight BRAM address
W_DI  out  DATA_W  weight BRAM write data
W_EN  out  1  weight BRAM enable
W_WE  out  1  weight BRAM write enable
W_DO  in  DATA_W  weight BRAM read data
X_ADDR  out  ADDR_W  input BRAM address
X_EN  out  1  input BRAM enable
X_DO  in  DATA_W  input BRAM read data

Behaviour:
- Reset (RST high at a rising edge, also mid-operation): state IDLE, counters and accumulator 0. Outputs: BUSY=0, DONE=0, RESULT=0, W_EN=0, X_EN=0, W_WE=0, W_ADDR=0, X_ADDR=0, W_DI=0. Any in-flight dot product is abandoned with no DONE.
- Memory timing: address/EN are driven from registers changed on the rising edge; the BRAMs sample them on the next falling edge. W_DO/X_DO are therefore valid at the next rising edge. Read latency is one cycle.
- IDLE state:
  - W_ADDR/W_DI/W_WE/W_EN combinationally follow the loader: W_EN=W_WE=LOAD_WE, W_ADDR=LOAD_ADDR, W_DI=LOAD_DATA.
  - X_EN=0.
  - START=1 → go to READ, issue address 0 (W_EN=X_EN=1, W_WE=0), capture BIAS, clear the accumulator, BUSY=1.
- READ state:
  - Issue addresses 1..NUM_W-1 on successive cycles.
  - At each edge, accumulate the product of the data returned for the previous address.
  - After issuing NUM_W-1, go to DRAIN and drop W_EN/X_EN.
- DRAIN state: accumulate the last product (address NUM_W-1), then go to FINISH.
- FINISH state: register RESULT=sat16((acc >>> FRAC_BITS) + BIAS), assert DONE for that one cycle, then return to IDLE.
- Latency: START accepted at edge t0 → DONE high in the cycle following edge t0+NUM_W+1 (29 edges for NUM_W=28). The next START is accepted on the cycle DONE is high (state is IDLE at the following edge) or later.
- Arithmetic:
  - Product: signed DATA_W×DATA_W → 2·DATA_W, sign-extended to ACC_W.
  - Scaling: arithmetic right shift by FRAC_BITS (floor) applied once, after accumulation.
  - Bias: sign-extended and added after the shift.
  - Saturation: result clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Arbitration:
  - LOAD_BUSY = (state≠IDLE) | START.
  - A LOAD_WE in the same cycle as an accepted START is dropped; compute wins.
  - Loader writes while BUSY are dropped and never reach the BRAM.
- START while BUSY: ignored, no queuing.
- Address counter: never exceeds NUM_W-1; no wrap.

Decomposition:
- Shared package ann_pkg: DATA_W, FRAC_BITS, ACC_W, state enum {IDLE, READ, DRAIN, FINISH}, and sat function from ACC_W to DATA_W.
- One natural sub-module, mac_sat_unit: signed multiply, accumulate, clear, and final shift/bias/saturate. The FSM, address generation and load mux stay in the top level.

Test Plan:
- All weights 0x0100, all inputs 0x0100, BIAS 0, START → DONE exactly 29 edges after START; RESULT=0x1C00 (28.0).
- Weights 0xFF00 (−1.0), inputs 0x0200 (2.0), BIAS 0x0100 → RESULT=0xC900 (−55.0).
- Weights 0x7FFF, inputs 0x7FFF → RESULT=0x7FFF. Weights 0x8000, inputs 0x7FFF → RESULT=0x8000.
- LOAD_WE pulses while BUSY: W_WE stays 0 and LOAD_BUSY=1. Rewrite address 5 to 0x0000 in IDLE, rerun the first case → RESULT=0x1B00.
- START and LOAD_WE in the same IDLE cycle → write dropped (W_WE=0), compute runs. A second START mid-run is ignored and produces exactly one DONE.
- RST asserted at edge t0+10 of a run → next cycle BUSY=0, DONE=0, RESULT=0, W_EN=X_EN=0, and no DONE follows. A fresh START then gives the correct result.
